// File: rtl/uart_rx_pkg.sv
// Shared FSM type, prescale constants and sampling helpers for the UART receiver.
// The PARITY state is present only when RX_PARITY_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Three samples straddle mid-bit: mid-EARLY, mid, mid+LATE.
  localparam int SMP_EARLY_OFS = 1;
  localparam int SMP_LATE_OFS  = 1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Bit timing for the UART receiver: oversampling edge counter, 3-point majority
// sampler and the bit_end strobe that paces the frame FSM.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  active,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_end,
  output logic                  bit_val
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] mid;
  logic [2:0]            smp;

  assign mid     = prescale >> 1;
  assign bit_end = active && (edge_cnt == prescale - ONE);
  assign bit_val = maj3(smp);

  // The IDLE cycle that saw the falling edge counts as edge 0, so the count resumes at 1.
  // An illegal prescale simply lets the counter wrap, which bounds every bit to 2^PRESCALE_W cycles.
  always_ff @(posedge clk) begin
    if (rst)                    edge_cnt <= '0;
    else if (start)             edge_cnt <= ONE;
    else if (!active || bit_end) edge_cnt <= '0;
    else                        edge_cnt <= edge_cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (active) begin
      if (edge_cnt == mid - PRESCALE_W'(SMP_EARLY_OFS)) smp[0] <= rx;
      if (edge_cnt == mid)                              smp[1] <= rx;
      if (edge_cnt == mid + PRESCALE_W'(SMP_LATE_OFS))  smp[2] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx_frame_deserializer.sv
// UART frame deserializer: start detect, LSB-first data shift, optional parity and
// stop check, parallel word with one-cycle DATA_VALID. Parity support needs RX_PARITY_EN.
module uart_rx_frame_deserializer
  import uart_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  RX_BUSY
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  rx_state_t             state, next_state;
  logic [PRESCALE_W-1:0] pres_lat;
  logic [BCW-1:0]        bit_cnt;
  logic [WIDTH-1:0]      shift_reg;
  logic                  frame_start;
  logic                  bit_end, bit_val;
  logic                  par_fail;

  assign frame_start = (state == IDLE) && !RX_IN;

  uart_rx_bit_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk     (CLK),
    .rst     (RST),
    .start   (frame_start),
    .active  (state != IDLE),
    .rx      (RX_IN),
    .prescale(pres_lat),
    .bit_end (bit_end),
    .bit_val (bit_val)
  );

`ifdef RX_PARITY_EN
  logic par_act, par_typ_lat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_act     <= 1'b0;
      par_typ_lat <= 1'b0;
      par_fail    <= 1'b0;
    end else if (frame_start) begin
      par_act     <= PAR_EN;
      par_typ_lat <= PAR_TYP;
      par_fail    <= 1'b0;
    end else if (state == PARITY && bit_end) begin
      par_fail <= bit_val != (par_typ_lat ? ~^shift_reg : ^shift_reg);
    end
  end
`else
  logic unused_par_cfg;
  assign par_fail       = 1'b0;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!RX_IN) next_state = START;
      START:  if (bit_end) next_state = bit_val ? IDLE : DATA;
      DATA:   if (bit_end && bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
                next_state = par_act ? PARITY : STOP;
`else
                next_state = STOP;
`endif
              end
`ifdef RX_PARITY_EN
      PARITY: if (bit_end) next_state = STOP;
`endif
      STOP:   if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pres_lat   <= '0;
      bit_cnt    <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      RX_BUSY    <= 1'b0;
    end else begin
      state      <= next_state;
      RX_BUSY    <= next_state != IDLE;
      DATA_VALID <= 1'b0;
      if (frame_start) begin
        pres_lat <= PRESCALE;
        bit_cnt  <= '0;
        PAR_ERR  <= 1'b0;
        STP_ERR  <= 1'b0;
      end
      if (state == DATA && bit_end)
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
      // A frame with any error leaves the previous word in place and raises no pulse.
      if (state == STOP && bit_end) begin
        STP_ERR <= !bit_val;
        PAR_ERR <= par_fail;
        if (bit_val && !par_fail) begin
          P_DATA     <= shift_reg;
          DATA_VALID <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state == DATA && bit_end) shift_reg <= {bit_val, shift_reg[WIDTH-1:1]};
  end

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Self-checking bench for uart_rx_frame_deserializer: frame-level reference model
// decoded from the recorded line history, plus directed literal checks.
module tb_uart_rx_frame_deserializer;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 6;
  localparam int HN         = 16384;
`ifdef RX_PARITY_EN
  localparam int PA = 1;
`else
  localparam int PA = 0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN, PAR_TYP;
  logic [WIDTH-1:0]      P_DATA;
  logic                  DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY;

  uart_rx_frame_deserializer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .RX_BUSY(RX_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;
  bit hist [0:HN-1];
  int pulse_cyc[$];
  logic [WIDTH-1:0] pulse_dat[$];

  // Reference model state: frame start index, latched ratio and parity settings.
  bit m_idle = 1'b1, m_odd = 1'b0;
  int m_s = 0, m_P = 8, m_pa = 0;
  logic [WIDTH-1:0] e_data = '0;
  bit e_valid = 1'b0, e_par = 1'b0, e_stp = 1'b0, e_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bit_at(input int k);
    int b, ones;
    b = m_s + k * m_P + m_P / 2 - 1;
    ones = int'(hist[b % HN]) + int'(hist[(b + 1) % HN]) + int'(hist[(b + 2) % HN]);
    return ones >= 2;
  endfunction

  function automatic void decode_frame();
    logic [WIDTH-1:0] d;
    bit stop, pbad;
    for (int j = 0; j < WIDTH; j++) d[j] = bit_at(1 + j);
    stop = bit_at(WIDTH + 1 + m_pa);
    pbad = (m_pa == 1) && (bit_at(WIDTH + 1) != (m_odd ? ~^d : ^d));
    e_stp = !stop;
    e_par = pbad;
    if (stop && !pbad) begin
      e_valid = 1'b1;
      e_data  = d;
    end
    m_idle = 1'b1;
  endfunction

  initial forever begin
    @(posedge CLK);
    hist[cyc % HN] = RX_IN;
    e_valid = 1'b0;
    if (RST) begin
      m_idle = 1'b1; e_data = '0; e_par = 1'b0; e_stp = 1'b0;
    end else if (m_idle) begin
      if (!RX_IN) begin
        m_idle = 1'b0; m_s = cyc; m_P = int'(PRESCALE);
        m_pa = (PA == 1 && PAR_EN) ? 1 : 0; m_odd = PAR_TYP;
        e_par = 1'b0; e_stp = 1'b0;
      end
    end else if (cyc == m_s + m_P - 1 && bit_at(0)) begin
      m_idle = 1'b1;
    end else if (cyc == m_s + (WIDTH + 2 + m_pa) * m_P - 1) begin
      decode_frame();
    end
    e_busy = !m_idle;
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (DATA_VALID === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(P_DATA);
    end
    if (chk_en) begin
      check("model_valid", 32'(DATA_VALID), 32'(e_valid));
      check("model_data",  32'(P_DATA),     32'(e_data));
      check("model_parerr", 32'(PAR_ERR),   32'(e_par));
      check("model_stperr", 32'(STP_ERR),   32'(e_stp));
      check("model_busy",  32'(RX_BUSY),    32'(e_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input int p, input logic pe,
                            input logic pt, input logic flip, input logic stop_bit,
                            output int s);
    bit fr[$];
    PRESCALE = PRESCALE_W'(p); PAR_EN = pe; PAR_TYP = pt;
    s = cyc;
    fr.push_back(1'b0);
    for (int j = 0; j < WIDTH; j++) fr.push_back(d[j]);
    if (PA == 1 && pe) fr.push_back((pt ? ~^d : ^d) ^ flip);
    fr.push_back(stop_bit);
    foreach (fr[k]) begin
      RX_IN = fr[k];
      tick(p);
    end
    RX_IN = 1'b1;
  endtask

  function automatic int lat_from(input int np, input int s);
    return (pulse_cyc.size() > np) ? pulse_cyc[np] - s : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s, s2, np;
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(3);
    check("rst_pdata", 32'(P_DATA), 0);
    check("rst_valid", 32'(DATA_VALID), 0);
    check("rst_flags", 32'({PAR_ERR, STP_ERR}), 0);
    check("rst_busy", 32'(RX_BUSY), 0);
    RST = 1'b0; chk_en = 1'b1;
    tick(4);

    np = pulse_cyc.size();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, s);
    tick(3);
    check("a5_latency", lat_from(np, s), 80);
    check("a5_data", 32'(P_DATA), 32'hA5);
    check("a5_flags", 32'({PAR_ERR, STP_ERR}), 0);

    np = pulse_cyc.size();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, s);
    tick(3);
    check("3c_latency", lat_from(np, s), (10 + PA) * 16);
    check("3c_data", 32'(P_DATA), 32'h3C);
    np = pulse_cyc.size();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, s);
    tick(3);
    check("badpar_pulses", pulse_cyc.size(), np + 1 - PA);
    check("badpar_parerr", 32'(PAR_ERR), PA);
    check("badpar_data", 32'(P_DATA), 32'h3C);

    np = pulse_cyc.size();
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, s);
    tick(3);
    check("stp_err", 32'(STP_ERR), 1);
    check("stp_no_pulse", pulse_cyc.size(), np);
    check("stp_data_held", 32'(P_DATA), 32'h3C);
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, s);
      begin
        tick(3);
        check("restart_clears_stp", 32'(STP_ERR), 0);
        check("restart_busy", 32'(RX_BUSY), 1);
      end
    join
    tick(3);
    check("33_data", 32'(P_DATA), 32'h33);

    np = pulse_cyc.size();
    PRESCALE = 6'd16;
    RX_IN = 1'b0;
    tick(3);
    check("glitch_busy", 32'(RX_BUSY), 1);
    RX_IN = 1'b1;
    tick(30);
    check("glitch_idle", 32'(RX_BUSY), 0);
    check("glitch_no_pulse", pulse_cyc.size(), np);
    check("glitch_flags", 32'({PAR_ERR, STP_ERR}), 0);

    np = pulse_cyc.size();
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, s);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, s2);
    tick(3);
    check("b2b_pulses", pulse_cyc.size(), np + 2);
    check("b2b_spacing", (pulse_cyc.size() >= np + 2) ? pulse_cyc[np + 1] - pulse_cyc[np] : -1,
          (10 + PA) * 32);
    check("b2b_first", (pulse_cyc.size() >= np + 2) ? 32'(pulse_dat[np]) : 32'hDEAD, 32'h01);
    check("b2b_second", 32'(P_DATA), 32'hFF);

    PRESCALE = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0; tick(8);
    RX_IN = 1'b1; tick(8);
    RX_IN = 1'b0; tick(8);
    RST = 1'b1; tick(1);
    check("midrst_outputs", 32'({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY}), 0);
    RST = 1'b0; RX_IN = 1'b1;
    tick(10);
    np = pulse_cyc.size();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, s);
    tick(3);
    check("5a_pulse", pulse_cyc.size(), np + 1);
    check("5a_data", 32'(P_DATA), 32'h5A);

    np = pulse_cyc.size();
    RX_IN = 1'b0;
    tick(160);
    RX_IN = 1'b1;
    check("stuck_stperr", 32'(STP_ERR), 1);
    check("stuck_idle", 32'(RX_BUSY), 0);
    check("stuck_no_pulse", pulse_cyc.size(), np);
    tick(3);

    chk_en = 1'b0;
    PRESCALE = 6'd0;
    RX_IN = 1'b0; tick(1);
    RX_IN = 1'b1;
    check("illegal_p_busy", 32'(RX_BUSY), 1);
    for (int k = 0; k < (WIDTH + 3) * 64 + 2; k++) begin
      if (RX_BUSY == 1'b0) break;
      tick(1);
    end
    check("illegal_p_recovers", 32'(RX_BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
